// File: rtl/encoder_8_to_3_serial_pkg.sv
// Shared types, widths and helpers for the serial 8-to-3 encoder.
package encoder_8_to_3_serial_pkg;

    localparam int VEC_W = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] popcount8(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < VEC_W; i++) begin
            cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/encoder_8_to_3_serial_prio_enc_8.sv
// Fixed 8-way priority encoder: selects the lowest (or highest) set bit and
// reports its index, a one-hot mask of it, and whether at most one bit is set.
module prio_enc_8
    import encoder_8_to_3_serial_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic [VEC_W-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic [VEC_W-1:0] onehot_mask,
    output logic             at_most_one
);

    logic [VEC_W-1:0] scan_vec;
    logic [VEC_W-1:0] scan_mask;
    logic [IDX_W-1:0] scan_idx;

    // Highest-first is handled by bit-reversing around a lowest-set-bit isolator.
    genvar gi;
    generate
        for (gi = 0; gi < VEC_W; gi++) begin : g_scan
            if (MSB_FIRST != 0) begin : g_flip
                assign scan_vec[gi]    = vec[VEC_W-1-gi];
                assign onehot_mask[gi] = scan_mask[VEC_W-1-gi];
            end else begin : g_keep
                assign scan_vec[gi]    = vec[gi];
                assign onehot_mask[gi] = scan_mask[gi];
            end
        end
    endgenerate

    assign scan_mask   = scan_vec & (~scan_vec + 8'd1);
    assign scan_idx[0] = |(scan_mask & 8'hAA);
    assign scan_idx[1] = |(scan_mask & 8'hCC);
    assign scan_idx[2] = |(scan_mask & 8'hF0);

    always_comb begin
        idx = scan_idx;
        if (vec == '0) begin
            idx = '0;
        end else if (MSB_FIRST != 0) begin
            idx = 3'd7 - scan_idx;
        end
    end

    assign at_most_one = ((vec & (vec - 8'd1)) == 8'd0);

endmodule

// File: rtl/encoder_8_to_3_serial.sv
// Serialises the set bits of an 8-bit request vector into one 3-bit index
// per output beat, with valid/ready handshakes on both sides.
module encoder_8_to_3_serial
    import encoder_8_to_3_serial_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] X,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] Y,
    output logic             out_last,
    output logic             out_none,
    output logic             out_multi,
    output logic [CNT_W-1:0] out_count
);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] pend_q, pend_d;
    logic             multi_q, multi_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IDX_W-1:0] sel_idx;
    logic [VEC_W-1:0] sel_mask;
    logic             sel_last;
    logic [CNT_W-1:0] x_count;

    prio_enc_8 #(
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .vec         (pend_q),
        .idx         (sel_idx),
        .onehot_mask (sel_mask),
        .at_most_one (sel_last)
    );

    assign x_count = popcount8(X);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            multi_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            multi_q <= multi_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        multi_d = multi_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pend_d  = X;
                    count_d = x_count;
                    multi_d = (x_count > 4'd1);
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_d = pend_q & ~sel_mask;
                    if (sel_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend only on registered state, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        Y         = '0;
        out_last  = 1'b0;
        out_none  = 1'b0;
        out_multi = 1'b0;
        out_count = '0;
        if (state_q == EMIT) begin
            Y         = sel_idx;
            out_last  = sel_last;
            out_none  = (pend_q == '0);
            out_multi = multi_q;
            out_count = count_q;
        end
    end

endmodule
